// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// mdu_unit : multi-cycle MULT/MULTU/DIV/DIVU engine owning architectural HI/LO
// Rev 1.0  : initial release
// ============================================================================
module mdu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        StallE,
    input  logic        Exception_clean,
    output logic        ALU_stall,
    output logic        ALU_done,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Latched operation context
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] raw_a;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic        op_is_div;

    // Arithmetic state
    logic [63:0] prod;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [4:0]  cnt;

    logic        is_muldiv;
    logic        is_mul;
    logic        is_signed_op;
    logic        accept;
    logic        commit;
    logic        mt_ok;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        qbit;
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_muldiv    = (op_i >= OP_MULT) && (op_i <= OP_DIVU);
    assign is_mul       = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign accept       = (state == IDLE) && is_muldiv && !Exception_clean;
    assign commit       = (state == DONE) && !StallE && !Exception_clean;
    assign mt_ok        = (state == IDLE) && !StallE && !Exception_clean;

    // Restoring step: shift in the next dividend bit, subtract if no borrow
    assign trial = {rem, mag_a[31]};
    assign diff  = trial - {1'b0, mag_b};
    assign qbit  = !diff[32];

    // Sign correction applied to the held raw result while in DONE
    assign prod_s = neg_res ? (64'd0 - prod) : prod;
    assign quo_s  = div_zero ? 32'hFFFF_FFFF : (neg_res ? (32'd0 - quo) : quo);
    assign rem_s  = div_zero ? raw_a : (neg_rem ? (32'd0 - rem) : rem);
    assign res_hi = op_is_div ? rem_s : prod_s[63:32];
    assign res_lo = op_is_div ? quo_s : prod_s[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ALU_stall  = 1'b0;
        ALU_done   = 1'b0;
        case (state)
            IDLE: begin
                ALU_stall = is_muldiv;
                if (accept) begin
                    state_next = is_mul ? MUL : DIV;
                end
            end
            MUL: begin
                ALU_stall  = 1'b1;
                state_next = DONE;
            end
            DIV: begin
                ALU_stall = 1'b1;
                if (cnt == 5'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ALU_stall = 1'b1;
                ALU_done  = 1'b1;
                if (!StallE) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (Exception_clean) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a     <= 32'd0;
            mag_b     <= 32'd0;
            raw_a     <= 32'd0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            div_zero  <= 1'b0;
            op_is_div <= 1'b0;
            prod      <= 64'd0;
            rem       <= 32'd0;
            quo       <= 32'd0;
            cnt       <= 5'd0;
        end else if (accept) begin
            mag_a     <= (is_signed_op && a_i[31]) ? (32'd0 - a_i) : a_i;
            mag_b     <= (is_signed_op && b_i[31]) ? (32'd0 - b_i) : b_i;
            raw_a     <= a_i;
            neg_res   <= is_signed_op && (a_i[31] ^ b_i[31]);
            neg_rem   <= is_signed_op && a_i[31];
            div_zero  <= (b_i == 32'd0);
            op_is_div <= !is_mul;
            rem       <= 32'd0;
            quo       <= 32'd0;
            cnt       <= 5'd31;
        end else if (state == MUL) begin
            prod <= {32'd0, mag_a} * {32'd0, mag_b};
        end else if (state == DIV) begin
            // mag_a doubles as the dividend shift register
            mag_a <= {mag_a[30:0], 1'b0};
            rem   <= qbit ? diff[31:0] : trial[31:0];
            quo   <= {quo[30:0], qbit};
            cnt   <= cnt - 5'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (commit) begin
            hi_o <= res_hi;
            lo_o <= res_lo;
        end else if (mt_ok) begin
            if (op_i == OP_MTHI) begin
                hi_o <= a_i;
            end
            if (op_i == OP_MTLO) begin
                lo_o <= a_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// tb_mdu_unit : randomized scoreboard bench for mdu_unit
// Rev 1.0     : initial release
// ============================================================================
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall_e;
    logic        exc;
    logic        alu_stall;
    logic        alu_done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit dut (
        .clk             (clk),
        .rst             (rst),
        .op_i            (op),
        .a_i             (a),
        .b_i             (b),
        .StallE          (stall_e),
        .Exception_clean (exc),
        .ALU_stall       (alu_stall),
        .ALU_done        (alu_done),
        .hi_o            (hi),
        .lo_o            (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of each operation, straight from the arithmetic rules
    function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint      p;
        logic [63:0] pu;
        int          sx;
        int          sy;
        rh = 32'd0;
        rl = 32'd0;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'd1: begin
                p  = longint'(sx) * longint'(sy);
                rh = p[63:32];
                rl = p[31:0];
            end
            3'd2: begin
                pu = {32'd0, x} * {32'd0, y};
                rh = pu[63:32];
                rl = pu[31:0];
            end
            3'd3: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    rh = 32'd0; rl = 32'h8000_0000;
                end else begin
                    rl = sx / sy;
                    rh = sx % sy;
                end
            end
            3'd4: begin
                if (y == 32'd0) begin
                    rh = x; rl = 32'hFFFF_FFFF;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    // Monitor: every commit handshake must match the next scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && alu_done && !stall_e && !exc) begin
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check("commit_hi", hi, e.hi);
                    check("commit_lo", lo, e.lo);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    // Entered at posedge+1 with the unit idle; returns at posedge+1 after commit
    task automatic run_muldiv(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] h0;
        logic [31:0] l0;
        int          t;
        ref_model(o, x, y, eh, el);
        check("done_low_before_accept", alu_done, 1'b0);
        op = o; a = x; b = y; stall_e = 1'b1;
        #1;
        check("stall_at_accept", alu_stall, 1'b1);
        h0 = hi;
        l0 = lo;
        t  = 0;
        while (!alu_done && t < 60) begin
            @(posedge clk);
            #1;
            t++;
            a = $urandom();
            b = $urandom();
        end
        check("done_latency", t, (o <= 3'd2) ? 2 : 33);
        check("hilo_hold_busy", {hi, lo}, {h0, l0});
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("done_held", alu_done, 1'b1);
            check("hilo_held_stalled", {hi, lo}, {h0, l0});
        end
        stall_e = 1'b0;
        sb.push_back('{hi: eh, lo: el});
        m_hi = eh;
        m_lo = el;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] x, input logic st);
        op = o; a = x; stall_e = st;
        #1;
        check("mt_no_stall", alu_stall, 1'b0);
        @(posedge clk);
        #1;
        if (!st) begin
            if (o == 3'd5) m_hi = x;
            else           m_lo = x;
        end
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
        op = 3'd0; stall_e = 1'b0;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;

        rst = 1'b1; op = 3'd0; a = 32'd0; b = 32'd0; stall_e = 1'b0; exc = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_stall", alu_stall, 1'b0);
        check("reset_done", alu_done, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_muldiv(3'd1, 32'hFFFF_FFFD, 32'd5, 0);
        run_muldiv(3'd2, 32'hFFFF_FFFD, 32'd5, 0);
        run_muldiv(3'd3, 32'hFFFF_FFF9, 32'd2, 0);
        run_muldiv(3'd4, 32'd100, 32'd7, 0);
        run_muldiv(3'd3, 32'h1234_5678, 32'd0, 0);
        run_muldiv(3'd4, 32'd9, 32'd2, 4);
        run_muldiv(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_muldiv(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_muldiv(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 0);

        run_mt(3'd5, 32'hCAFE_BABE, 1'b0);
        run_mt(3'd6, 32'h1357_9BDF, 1'b0);
        run_mt(3'd6, 32'hDEAD_BEEF, 1'b1);
        run_mt(3'd5, 32'h0BAD_F00D, 1'b1);

        // Flush at T10 of a divide
        op = 3'd3; a = 32'd1000; b = 32'd3; stall_e = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        exc = 1'b1; op = 3'd0;
        @(posedge clk);
        #1;
        exc = 1'b0;
        check("abort_stall", alu_stall, 1'b0);
        check("abort_done", alu_done, 1'b0);
        check("abort_hilo", {hi, lo}, {m_hi, m_lo});
        stall_e = 1'b0;

        // Flush while the result is waiting in DONE
        op = 3'd1; a = 32'd77; b = 32'd11; stall_e = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("flush_done_reached", alu_done, 1'b1);
        exc = 1'b1; stall_e = 1'b0; op = 3'd0;
        @(posedge clk);
        #1;
        exc = 1'b0;
        check("flush_done_hilo", {hi, lo}, {m_hi, m_lo});
        check("flush_done_stall", alu_stall, 1'b0);

        // Randomized mix
        for (int i = 0; i < 28; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom();
            y = $urandom();
            if ($urandom_range(0, 7) == 0) y = 32'd0;
            if ($urandom_range(0, 9) == 0) y = 32'd1 + 32'($urandom_range(0, 15));
            if (o >= 3'd1 && o <= 3'd4) begin
                run_muldiv(o, x, y, $urandom_range(0, 3));
            end else if (o == 3'd5 || o == 3'd6) begin
                run_mt(o, x, 1'($urandom_range(0, 1)));
            end else begin
                op = o; a = x; b = y; stall_e = 1'($urandom_range(0, 1));
                #1;
                check("none_no_stall", alu_stall, 1'b0);
                @(posedge clk);
                #1;
                check("none_hilo", {hi, lo}, {m_hi, m_lo});
                stall_e = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a divide
        op = 3'd4; a = 32'hFFFF_0000; b = 32'd13; stall_e = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midop_reset_hi", hi, 32'd0);
        check("midop_reset_lo", lo, 32'd0);
        check("midop_reset_done", alu_done, 1'b0);
        m_hi = 32'd0; m_lo = 32'd0;
        op = 3'd0; stall_e = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_reset_stall", alu_stall, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit in the EX stage, owning the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU, MTHI and MTLO. It produces the `ALU_stall`/`ALU_done` pair that the hazard controller consumes: EX, D and F are held while an operation is in flight, then released for exactly one completion handshake. HI/LO commit only when the owning instruction actually leaves EX and has not been cancelled.

## Interface

- No parameters; datapath fixed at 32 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op_i` input 3: EX-stage operation. 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 treated as none.
- `a_i` input 32: rs operand (dividend / multiplicand / MT source).
- `b_i` input 32: rt operand (divisor / multiplier).
- `StallE` input 1: EX register held this cycle (from hazard controller).
- `Exception_clean` input 1: pipeline flush. Aborts any operation; no HI/LO write.
- `ALU_stall` output 1: a mult/div is present in EX and not yet retired.
- `ALU_done` output 1: result ready; EX may advance.
- `hi_o` output 32: current HI (MFHI source).
- `lo_o` output 32: current LO (MFLO source).

## Operation

- States: IDLE, MUL, DIV, DONE. Async reset: IDLE, `hi_o`=`lo_o`=0, iteration counter 0, `ALU_stall`=`ALU_done`=0.
- `ALU_stall` = (IDLE and `op_i` in {001..100}) or state in {MUL, DIV, DONE}. Combinational, so it asserts in the accept cycle.
- `ALU_done` = (state == DONE). The hazard controller stalls on `ALU_stall && !ALU_done`.
- IDLE, `op_i` is mult/div, `Exception_clean`=0: latch the operand magnitudes, sign flags and op. Go to MUL (mult) or DIV (div). `op_i`, `a_i` and `b_i` are ignored after acceptance.
- MUL: one cycle computes the 64-bit product with a registered result, then DONE. Signed: the product is formed on magnitudes and negated if the signs differ.
- DIV: restoring radix-2, one quotient bit per cycle, counter 31 down to 0, 32 cycles, then DONE.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend (raw `a_i`). Same 32-cycle latency.
- DONE, `StallE`=0, `Exception_clean`=0: write HI = product[63:32] / remainder and LO = product[31:0] / quotient, then go to IDLE.
- DONE, `StallE`=1: remain in DONE, result held, no write. This covers stalls from other causes (e.g. MEM); there is no re-execution.
- `Exception_clean`=1 in any state: next state IDLE, no HI/LO write, in-flight result discarded. This takes priority over every other transition.
- MTHI/MTLO: in IDLE with `StallE`=0 and `Exception_clean`=0, write `a_i` to HI/LO at the clock edge. No stall; `ALU_stall` stays 0.
- `hi_o`/`lo_o` are direct register outputs. A write is visible the cycle after commit; there is no bypass.

## Timing

- Accept cycle is T0.
- MULT/MULTU:
  - T0 IDLE, T1 MUL, T2 DONE (`ALU_done`=1).
  - HI/LO update at the end of T2 if `StallE`=0.
  - `ALU_stall`=1 for T0–T2.
- DIV/DIVU:
  - T0 IDLE, T1–T32 DIV, T33 DONE.
  - HI/LO update at the end of T33 if `StallE`=0.
  - `ALU_stall`=1 for T0–T33.
- Back-to-back: IDLE is entered at T+1 after DONE. A new op in EX is accepted that same cycle, giving no dead cycle between operations.
- A new mult/div is never accepted in DONE; the current EX instruction is still the finished one.
- Reset mid-operation: immediate IDLE; HI/LO return to 0.

## Test plan

- MULT a=0xFFFFFFFD (−3), b=5, `StallE`=0 after `ALU_done`:
  - `ALU_stall` high for 3 cycles, `ALU_done` high in the 3rd.
  - Then `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFF1.
  - MULTU with the same operands: `hi_o`=0x00000004, `lo_o`=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2:
  - `ALU_done` in cycle T33.
  - `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- DIVU a=100, b=7: `lo_o`=14, `hi_o`=2.
- DIV a=0x12345678, b=0: `lo_o`=0xFFFFFFFF, `hi_o`=0x12345678.
- DIVU 9/2 with `StallE`=1 held for 4 cycles in DONE:
  - `ALU_done` stays 1 and HI/LO are unchanged throughout.
  - HI=1, LO=4 are written the cycle `StallE` drops.
  - Exactly one write occurs; a following MULT is accepted the next cycle.
- Abort and move-to cases:
  - DIV started, `Exception_clean` pulsed at T10: state IDLE at T11, `ALU_stall`=0 with `op_i`=000, HI/LO unchanged.
  - MTHI 0xCAFEBABE with `StallE`=0: `hi_o`=0xCAFEBABE next cycle, `ALU_stall` never asserted.
  - MTLO with `StallE`=1: no write.
